// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, sync byte and sizing helpers for prog_loader.
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      COUNT = 3'd1,
      DATA  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4,
      ERROR = 3'd5
   } loader_state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   function automatic int nbytes(input int isz);
      return (isz + 7) / 8;
   endfunction

   // Bits of an instruction's first (MS) byte that lie above the instruction width.
   function automatic logic [7:0] first_byte_mask(input int isz);
      int unsigned excess;
      logic [7:0]  m;
      excess = int'(8 * nbytes(isz) - isz);
      m      = '0;
      for (int unsigned b = 0; b < 8; b++) begin
         if (b + excess >= 8) m[b] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/loader_csum.sv
// loader_csum: 8-bit running-sum accumulator with clear and add-on-accept;
// zero_o flags that the current sum plus the presented byte is 0 mod 256.
module loader_csum (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       clear_i,
   input  logic       add_i,
   input  logic [7:0] data_i,
   output logic       zero_o
);

   logic [7:0] sum_q;
   logic [7:0] sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clear_i) begin
         sum_d = '0;
      end else if (add_i) begin
         sum_d = sum_q + data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign zero_o = ((sum_q + data_i) == 8'h00);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader writing instructions into program memory and
// holding the CPU until a verified image is present. Optional CSUM check: PROG_LOADER_CHECKSUM_EN.
module prog_loader
   import loader_pkg::*;
#(
   parameter int p_size = 6,
   parameter int i_size = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              wr_en,
   output logic [p_size-1:0] wr_addr,
   output logic [i_size-1:0] wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   localparam int               NBYTES    = nbytes(i_size);
   localparam int unsigned      DEPTH     = 1 << p_size;
   localparam logic [7:0]       FB_MASK   = first_byte_mask(i_size);
   localparam int               BCW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [BCW-1:0]   LAST_BYTE = BCW'(NBYTES - 1);

   loader_state_t     state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic              wr_en_q, wr_en_d;
   logic [p_size-1:0] wr_addr_q, wr_addr_d;
   logic [i_size-1:0] wr_data_q, wr_data_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [7:0]        count_q, count_d;
   logic [7:0]        idx_q, idx_d;
   logic [p_size-1:0] addr_q, addr_d;
   logic [BCW-1:0]    bcnt_q, bcnt_d;
   logic [i_size-1:0] asm_q, asm_d;

   logic xfer;
   logic sync_xfer;

   assign xfer      = in_valid && in_ready_q;
   assign sync_xfer = xfer && (in_data == SYNC_BYTE);

`ifdef PROG_LOADER_CHECKSUM_EN
   logic csum_zero;

   loader_csum u_csum (
      .clk_i   (clk),
      .reset_i (reset),
      .clear_i (state_q == COUNT && xfer),
      .add_i   (state_q == DATA && xfer),
      .data_i  (in_data),
      .zero_o  (csum_zero)
   );
`endif

   always_comb begin
      state_d    = state_q;
      in_ready_d = 1'b1;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      cpu_hold_d = cpu_hold_q;
      done_d     = done_q;
      error_d    = error_q;
      count_d    = count_q;
      idx_d      = idx_q;
      addr_d     = addr_q;
      bcnt_d     = bcnt_q;
      asm_d      = asm_q;

      case (state_q)
         IDLE: begin
            if (sync_xfer) state_d = COUNT;
         end

         COUNT: begin
            if (xfer) begin
               count_d = in_data;
               idx_d   = '0;
               addr_d  = '0;
               bcnt_d  = '0;
               if (in_data == 8'h00 || 32'(in_data) > DEPTH) begin
                  state_d = ERROR;
                  error_d = 1'b1;
               end else begin
                  state_d = DATA;
               end
            end
         end

         // The write cycle itself decides whether the frame body is finished, so the
         // final write is never overlapped with the next state's first accepted byte.
         DATA: begin
            if (wr_en_q) begin
               if (idx_q == count_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                  state_d = CHECK;
`else
                  state_d    = DONE;
                  done_d     = 1'b1;
                  cpu_hold_d = 1'b0;
`endif
               end
            end else if (xfer) begin
               if (bcnt_q == '0 && (in_data & FB_MASK) != 8'h00) begin
                  state_d = ERROR;
                  error_d = 1'b1;
               end else begin
                  asm_d = i_size'({asm_q, in_data});
                  if (bcnt_q == LAST_BYTE) begin
                     bcnt_d     = '0;
                     wr_en_d    = 1'b1;
                     in_ready_d = 1'b0;
                     wr_addr_d  = addr_q;
                     wr_data_d  = asm_d;
                     addr_d     = addr_q + p_size'(1);
                     idx_d      = idx_q + 8'd1;
                  end else begin
                     bcnt_d = bcnt_q + BCW'(1);
                  end
               end
            end
         end

`ifdef PROG_LOADER_CHECKSUM_EN
         CHECK: begin
            if (xfer) begin
               if (csum_zero) begin
                  state_d    = DONE;
                  done_d     = 1'b1;
                  cpu_hold_d = 1'b0;
               end else begin
                  state_d = ERROR;
                  error_d = 1'b1;
               end
            end
         end
`endif

         DONE: begin
            if (sync_xfer) begin
               state_d    = COUNT;
               done_d     = 1'b0;
               cpu_hold_d = 1'b1;
            end
         end

         ERROR: begin
            if (sync_xfer) begin
               state_d = COUNT;
               error_d = 1'b0;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         cpu_hold_q <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         count_q    <= '0;
         idx_q      <= '0;
         addr_q     <= '0;
         bcnt_q     <= '0;
         asm_q      <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
         error_q    <= error_d;
         count_q    <= count_d;
         idx_q      <= idx_d;
         addr_q     <= addr_d;
         bcnt_q     <= bcnt_d;
         asm_q      <= asm_d;
      end
   end

   assign in_ready = in_ready_q;
   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign cpu_hold = cpu_hold_q;
   assign done     = done_q;
   assign error    = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed and randomized frames against a frame-level reference model.
`timescale 1ns/1ps
module tb_prog_loader;

   localparam int P_SIZE = 6;
   localparam int I_SIZE = 20;
   localparam int NB     = (I_SIZE + 7) / 8;
   localparam int DEPTH  = 1 << P_SIZE;
`ifdef PROG_LOADER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [7:0]        in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              wr_en;
   logic [P_SIZE-1:0] wr_addr;
   logic [I_SIZE-1:0] wr_data;
   logic              cpu_hold;
   logic              done;
   logic              error;

   prog_loader #(.p_size(P_SIZE), .i_size(I_SIZE)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int addr; logic [31:0] data; int idx; } wr_t;
   typedef struct { bit is_done; int idx; } ev_t;

   wr_t        exp_wr[$];
   ev_t        exp_ev[$];
   int         acc_edge[int];
   logic [7:0] frm[$];
   int         bidx = 0;
   bit         m_done = 1'b0;
   bit         m_error = 1'b0;
   bit         mon_en = 1'b0;
   int         gap_mode = 0;
   bit         tog = 1'b0;
   int         n_cmp = 0;
   int         n_bad = 0;
   wr_t        mw;
   ev_t        me;
   logic       done_p = 1'b0;
   logic       err_p = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: parse the byte stream by frame rules, producing writes and flag events.
   task automatic model_frame(input int base);
      int         i = 0;
      int         n;
      logic [31:0] word;
      logic [7:0] sum;
      bit         ok;
      while (i < frm.size()) begin
         if (frm[i] != 8'hA5) begin i++; continue; end
         m_done = 1'b0; m_error = 1'b0; i++;
         if (i >= frm.size()) break;
         n = int'(frm[i]);
         if (n == 0 || n > DEPTH) begin
            m_error = 1'b1; exp_ev.push_back('{1'b0, base + i}); i++; continue;
         end
         i++; sum = '0; ok = 1'b1;
         for (int k = 0; k < n; k++) begin
            if (i + NB > frm.size()) begin ok = 1'b0; i = frm.size(); break; end
            if ((int'(frm[i]) >> (I_SIZE - 8 * (NB - 1))) != 0) begin
               m_error = 1'b1; exp_ev.push_back('{1'b0, base + i}); i++; ok = 1'b0; break;
            end
            word = '0;
            for (int j = 0; j < NB; j++) begin
               word = (word << 8) | 32'(frm[i + j]);
               sum  = sum + frm[i + j];
            end
            exp_wr.push_back('{k, word, base + i + NB - 1});
            i += NB;
         end
         if (!ok) continue;
         if (CSUM_EN) begin
            if (i >= frm.size()) break;
            if (8'(sum + frm[i]) == 8'h00) begin
               m_done = 1'b1; exp_ev.push_back('{1'b1, base + i});
            end else begin
               m_error = 1'b1; exp_ev.push_back('{1'b0, base + i});
            end
            i++;
         end else begin
            m_done = 1'b1; exp_ev.push_back('{1'b1, base + i - 1});
         end
      end
   endtask

   always @(negedge clk) begin
      if (wr_en) begin
         if (exp_wr.size() == 0) begin
            check_eq("wr_unexpected", 32'(exp_wr.size()), 32'd1);
         end else begin
            mw = exp_wr.pop_front();
            check_eq("wr_addr", 32'(wr_addr), 32'(mw.addr));
            check_eq("wr_data", 32'(wr_data), mw.data);
            check_eq("wr_latency", 32'(cyc), 32'(acc_edge.exists(mw.idx) ? acc_edge[mw.idx] : -1));
         end
      end
      if (mon_en) check_eq("ready_bubble", 32'(in_ready), 32'(!wr_en));
      if (done && !done_p) begin
         if (exp_ev.size() == 0 || !exp_ev[0].is_done) begin
            check_eq("done_rise_expected", 32'(exp_ev.size() != 0 && exp_ev[0].is_done), 32'd1);
         end else begin
            me = exp_ev.pop_front();
            check_eq("done_latency", 32'(cyc), 32'(acc_edge[me.idx] + (CSUM_EN ? 0 : 1)));
         end
      end
      if (error && !err_p) begin
         if (exp_ev.size() == 0 || exp_ev[0].is_done) begin
            check_eq("error_rise_expected", 32'(exp_ev.size() != 0 && !exp_ev[0].is_done), 32'd1);
         end else begin
            me = exp_ev.pop_front();
            check_eq("error_latency", 32'(cyc), 32'(acc_edge[me.idx]));
         end
      end
      done_p = done;
      err_p  = error;
   end

   task automatic send_byte(input logic [7:0] b, input int idx);
      bit sent = 1'b0;
      int guard = 0;
      while (!sent && guard < 100) begin
         @(negedge clk);
         guard++;
         tog = ~tog;
         if ((gap_mode == 1 && $urandom_range(0, 2) == 0) || (gap_mode == 2 && tog)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
         end else begin
            in_valid = 1'b1;
            in_data  = b;
            if (in_ready) begin
               acc_edge[idx] = cyc + 1;
               sent = 1'b1;
            end
         end
      end
      if (!sent) check_eq("send_timeout", 32'(sent), 32'd1);
   endtask

   task automatic send_all(input int mode);
      int base = bidx;
      gap_mode = mode;
      model_frame(base);
      foreach (frm[i]) send_byte(frm[i], base + i);
      bidx += frm.size();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_frame(input int mode);
      send_all(mode);
      repeat (4) @(negedge clk);
      check_eq("done", 32'(done), 32'(m_done));
      check_eq("error", 32'(error), 32'(m_error));
      check_eq("cpu_hold", 32'(cpu_hold), 32'(!m_done));
      check_eq("wr_pending", 32'(exp_wr.size()), 32'd0);
      check_eq("ev_pending", 32'(exp_ev.size()), 32'd0);
   endtask

   task automatic load_hex(input logic [95:0] v, input int len);
      frm.delete();
      for (int i = 0; i < len; i++) frm.push_back(v[8 * (len - 1 - i) +: 8]);
   endtask

   task automatic build_rand(input int n, input bit corrupt, input bit bad_csum, input bit garbage);
      logic [31:0] w;
      logic [7:0]  sum = '0;
      logic [7:0]  b;
      int          bad_k;
      frm.delete();
      if (garbage) begin
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            frm.push_back(b);
         end
      end
      frm.push_back(8'hA5);
      frm.push_back(8'(n));
      bad_k = corrupt ? int'($urandom_range(0, n - 1)) : -1;
      for (int k = 0; k < n; k++) begin
         w = $urandom & ((32'd1 << I_SIZE) - 32'd1);
         if (k == bad_k) w = w | (32'd1 << (8 * NB - 1 - $urandom_range(0, 8 * NB - I_SIZE - 1)));
         for (int j = NB - 1; j >= 0; j--) begin
            b = 8'(w >> (8 * j));
            frm.push_back(b);
            sum = sum + b;
         end
      end
      if (CSUM_EN) frm.push_back(bad_csum ? 8'(sum + 8'd1 + 8'($urandom_range(0, 250))) : 8'(8'd0 - sum));
   endtask

   task automatic check_reset_vals(input string pfx);
      check_eq({pfx, "_in_ready"}, 32'(in_ready), 32'd0);
      check_eq({pfx, "_wr_en"},    32'(wr_en),    32'd0);
      check_eq({pfx, "_wr_addr"},  32'(wr_addr),  32'd0);
      check_eq({pfx, "_wr_data"},  32'(wr_data),  32'd0);
      check_eq({pfx, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
      check_eq({pfx, "_done"},     32'(done),     32'd0);
      check_eq({pfx, "_error"},    32'(error),    32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      reset = 1'b0;
      @(negedge clk);
      check_eq("ready_after_reset", 32'(in_ready), 32'd1);
      mon_en = 1'b1;

      load_hex(96'hA5_02_04_12_34_00_00_FF_B7, 9);
      run_frame(0);
      check_eq("t1_done", 32'(done), 32'd1);

      load_hex(96'hA5_02_04_12_34_00_00_FF_00, 9);
      run_frame(0);
      check_eq("t2_error", 32'(error), 32'(CSUM_EN));

      load_hex(96'hA5_41, 2);
      run_frame(1);
      check_eq("t3_err_n65", 32'(error), 32'd1);
      load_hex(96'hA5_00, 2);
      run_frame(0);
      check_eq("t3_err_n0", 32'(error), 32'd1);
      build_rand(3, 1'b0, 1'b0, 1'b0);
      run_frame(1);
      check_eq("t3_recover_err", 32'(error), 32'd0);

      load_hex(96'hA5_01_14_00_00, 5);
      run_frame(0);
      check_eq("t4_err_hibits", 32'(error), 32'd1);

      build_rand(3, 1'b0, 1'b0, 1'b0);
      frm.push_front(8'h22);
      frm.push_front(8'h11);
      run_frame(2);
      check_eq("t5_done", 32'(done), 32'd1);

      build_rand(4, 1'b0, 1'b0, 1'b0);
      while (frm.size() > 3 + 2 * NB) void'(frm.pop_back());
      send_all(0);
      repeat (3) @(negedge clk);
      check_eq("t6_wr_pending", 32'(exp_wr.size()), 32'd0);
      mon_en = 1'b0;
      reset  = 1'b1;
      @(negedge clk);
      check_reset_vals("midrst");
      reset   = 1'b0;
      m_done  = 1'b0;
      m_error = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      build_rand(4, 1'b0, 1'b0, 1'b0);
      run_frame(0);
      check_eq("t6_done", 32'(done), 32'd1);

      build_rand(DEPTH, 1'b0, 1'b0, 1'b0);
      run_frame(0);
      check_eq("t7_full_depth_done", 32'(done), 32'd1);

      for (int r = 0; r < 14; r++) begin
         build_rand(int'($urandom_range(1, 6)), $urandom_range(0, 4) == 0,
                    $urandom_range(0, 3) == 0, 1'b1);
         run_frame(int'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader for the picoMIPS core. It receives a framed instruction image on a byte-wide valid/ready input and writes it, one instruction per write, into the writable program memory that the CPU fetches from. It holds the CPU in reset until a complete, verified image has been written. It is the writer end of the program-memory interface whose reader is the CPU fetch path.

## Interface
- `p_size`, 6: program address width; memory depth is 2^p_size.
- `i_size`, 20: instruction width; `NBYTES = (i_size+7)/8` bytes per instruction (3 at default).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts the byte; a byte transfers when `in_valid && in_ready` at a rising edge.
- `wr_en` output 1: program-memory write strobe, one cycle.
- `wr_addr` output p_size: write address.
- `wr_data` output i_size: instruction word.
- `cpu_hold` output 1: active-high hold, ORed into the CPU reset by the top level.
- `done` output 1: a valid image is loaded.
- `error` output 1: frame error is latched.

## Operation
- Frame format: `SYNC` (0xA5), `COUNT` N, N×NBYTES instruction bytes MS byte first, then `CSUM` (with checksum enabled).
- Valid N is 1..2^p_size. N=0 or N>2^p_size goes to ERROR immediately after the `COUNT` byte. No writes occur in that case.
- In each instruction's first byte, bits above position `i_size-1` (i.e. above bit `i_size-8*(NBYTES-1)-1` of that byte) must be 0. A nonzero bit there goes to ERROR after that byte. No write occurs for that instruction.
- States:
  - IDLE: discard bytes until 0xA5 → COUNT.
  - COUNT: check N → DATA or ERROR. Clear the address counter and byte counter.
  - DATA: shift bytes into the assembler. On the NBYTES-th byte, issue a write and increment the address. After the Nth write → CHECK (or DONE if checksum is disabled).
  - CHECK: one byte. If the 8-bit sum of all instruction bytes plus `CSUM` ≡ 0 mod 256 → DONE, else → ERROR.
  - DONE: `done`=1, `cpu_hold`=0. A 0xA5 byte → COUNT; other bytes are discarded.
  - ERROR: `error`=1, `cpu_hold`=1. A 0xA5 byte → COUNT and clears `error`; other bytes are discarded.
- `cpu_hold` is 1 in every state except DONE.
- `done` clears on leaving DONE.
- Address counter is p_size bits. Wrap cannot occur because N ≤ 2^p_size.
- Writes already issued before a checksum failure remain in memory. `error` marks the image invalid.

## Timing
- All outputs are registered.
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_hold`=1, `done`=0, `error`=0, state IDLE.
- `in_ready` rises on the first edge after `reset` is released.
- Write latency: `wr_en`=1 in the cycle after the last byte of an instruction is accepted, with `wr_addr`/`wr_data` stable that cycle.
- `in_ready`=0 during each `wr_en` cycle (one bubble per instruction) and 1 otherwise.
- `in_valid` may be held or toggled freely. `in_data` is sampled only on a transfer.
- `done`/`cpu_hold` change in the cycle after the final byte (`CSUM`, or the last write cycle when checksum is disabled).
- Reset mid-frame: all outputs return to reset values on the next edge, and the partial frame is abandoned. `reset` takes priority over a simultaneous transfer.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - The `CSUM` byte is expected, and the CHECK state and checksum accumulator exist.
- `PROG_LOADER_CHECKSUM_EN` undefined:
  - There is no `CSUM` byte.
  - The loader goes DATA → DONE in the cycle after the Nth write.
  - The checksum logic is removed.

## Structure
- `loader_pkg`:
  - `loader_state_t` enum (IDLE, COUNT, DATA, CHECK, DONE, ERROR).
  - `SYNC_BYTE` = 8'hA5.
  - `nbytes(i_size)` function.
- Sub-module `loader_csum`: 8-bit running-sum accumulator with clear, add-on-accept and zero flag. It is instantiated only under `PROG_LOADER_CHECKSUM_EN`.

## Test plan
- Load 2 instructions, bytes `A5 02 04 12 34 00 00 FF B7` → writes (0, 0x41234) then (1, 0x000FF); then `done`=1, `cpu_hold`=0, `error`=0.
- Same frame with `CSUM`=0x00 → both writes occur; then `error`=1, `cpu_hold`=1, `done`=0.
- `A5 41` (N=65 at p_size 6), also `A5 00` → `error`=1 after `COUNT`, no `wr_en`; then a valid frame loads and clears `error`.
- `A5 01 14 00 00` → `error`=1 after byte 0x14, no write.
- Garbage `11 22` before `A5`, with `in_valid` toggled every other cycle → garbage is ignored, and the image loads correctly with one `in_ready` bubble per write.
- `reset` pulsed during DATA of a 4-instruction frame → all outputs return to reset values; the following full frame writes from address 0 and ends in DONE.
